dmadd_host_loader: RTL and testbench

- Host-side initiator for the DMADD nibble-load/run interface; drives the other end of that interface.
- Accepts one wide operand word plus a 2-bit instruction over a valid/ready command port.
- Serialises the word into indexed 4-bit writes (index/data/load), pulses run, waits a fixed latency, then captures the 16-bit result.
- Returns the result on a valid/ready response port. Sits on the host or bench side of DMADD, or in an on-chip sequencer ahead of it.

---
 rtl/dmadd_pkg.sv | 21 ++
 rtl/dmadd_nibble_pick.sv | 28 ++
 rtl/dmadd_host_loader.sv | 219 +++++++++++++++++++++
 tb/tb_dmadd_host_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmadd_pkg.sv
// Shared types and defaults for the DMADD host-side loader.
package dmadd_pkg;

  localparam int unsigned NIBBLE_W      = 4;
  localparam int unsigned IDX_W_DEFAULT = 4;
  localparam int unsigned RES_W_DEFAULT = 16;

  localparam logic [1:0] INSN_NOP = 2'b00;
  localparam logic [1:0] INSN_ADD = 2'b01;
  localparam logic [1:0] INSN_SUB = 2'b10;
  localparam logic [1:0] INSN_MAC = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/dmadd_nibble_pick.sv
// Priority selector: lowest set bit of diff_i at or above start_i.
module dmadd_nibble_pick
  import dmadd_pkg::*;
#(
  parameter int unsigned NIBBLES = 16,
  parameter int unsigned IDX_W   = IDX_W_DEFAULT
) (
  input  logic [NIBBLES-1:0] diff_i,
  input  logic [IDX_W:0]     start_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  localparam int unsigned SW = IDX_W + 1;

  // Scan downward so the lowest qualifying index wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = int'(NIBBLES) - 1; i >= 0; i--) begin
      if (diff_i[i] && (SW'(i) >= start_i)) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmadd_host_loader.sv
// Host-side DMADD initiator: serialises a command into nibble writes, runs, returns the result.
// Optional DMADD_SKIP_UNCHANGED_EN rewrites only nibbles that differ from the last loaded word.
module dmadd_host_loader
  import dmadd_pkg::*;
#(
  parameter int unsigned NIBBLES = 16,
  parameter int unsigned IDX_W   = IDX_W_DEFAULT,
  parameter int unsigned RUN_LAT = 2,
  parameter int unsigned RES_W   = RES_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_insn,
  input  logic [NIBBLE_W*NIBBLES-1:0] cmd_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [RES_W-1:0]           rsp_data,
  output logic                       busy,
  output logic                       mac_run,
  output logic                       mac_load,
  output logic [1:0]                 mac_insn,
  output logic [IDX_W-1:0]           mac_index,
  output logic [NIBBLE_W-1:0]        mac_data,
  input  logic [RES_W-1:0]           mac_out
);

  localparam int unsigned DATA_W = NIBBLE_W * NIBBLES;
  localparam int unsigned CNT_W  = (RUN_LAT > 1) ? $clog2(RUN_LAT) : 1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          insn_q, insn_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]    rsp_data_q, rsp_data_d;
  logic                mac_run_q, mac_run_d;
  logic                mac_load_q, mac_load_d;
  logic [1:0]          mac_insn_q, mac_insn_d;
  logic [IDX_W-1:0]    mac_index_q, mac_index_d;
  logic [NIBBLE_W-1:0] mac_data_q, mac_data_d;

  logic [DATA_W-1:0]   src;
  logic                adv_found;
  logic [IDX_W-1:0]    adv_idx;
  logic [NIBBLE_W-1:0] adv_nib;

  // In IDLE the word has not been latched yet, so look at the port directly.
  assign src     = (state_q == ST_IDLE) ? cmd_data : data_q;
  assign adv_nib = src[NIBBLE_W*adv_idx +: NIBBLE_W];

`ifdef DMADD_SKIP_UNCHANGED_EN
  localparam int unsigned SW = IDX_W + 1;

  logic [DATA_W-1:0]  shadow_q;
  logic               shadow_valid_q;
  logic [NIBBLES-1:0] diff;
  logic [IDX_W:0]     pick_start;

  always_comb begin
    diff = '0;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      diff[k] = !shadow_valid_q ||
                (src[k*NIBBLE_W +: NIBBLE_W] != shadow_q[k*NIBBLE_W +: NIBBLE_W]);
    end
  end

  assign pick_start = (state_q == ST_IDLE) ? '0 : ({1'b0, mac_index_q} + SW'(1));

  dmadd_nibble_pick #(
    .NIBBLES (NIBBLES),
    .IDX_W   (IDX_W)
  ) u_pick (
    .diff_i  (diff),
    .start_i (pick_start),
    .idx_o   (adv_idx),
    .found_o (adv_found)
  );

  // The word becomes the new reference once it is committed to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      shadow_q       <= data_q;
      shadow_valid_q <= 1'b1;
    end
  end
`else
  always_comb begin
    adv_found = 1'b1;
    adv_idx   = '0;
    if (state_q == ST_LOAD) begin
      adv_found = (mac_index_q != IDX_W'(NIBBLES - 1));
      adv_idx   = mac_index_q + IDX_W'(1);
    end
  end
`endif

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    insn_d      = insn_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    mac_run_d   = 1'b0;
    mac_load_d  = 1'b0;
    mac_index_d = '0;
    mac_data_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          data_d = cmd_data;
          insn_d = cmd_insn;
          if (adv_found) begin
            state_d     = ST_LOAD;
            mac_load_d  = 1'b1;
            mac_index_d = adv_idx;
            mac_data_d  = adv_nib;
          end else begin
            state_d   = ST_RUN;
            mac_run_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (adv_found) begin
          mac_load_d  = 1'b1;
          mac_index_d = adv_idx;
          mac_data_d  = adv_nib;
        end else begin
          state_d   = ST_RUN;
          mac_run_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (RUN_LAT == 0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = mac_out;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RUN_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = mac_out;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    mac_insn_d  = (state_d inside {ST_LOAD, ST_RUN, ST_WAIT}) ? insn_d : INSN_NOP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      insn_q      <= INSN_NOP;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      mac_run_q   <= 1'b0;
      mac_load_q  <= 1'b0;
      mac_insn_q  <= INSN_NOP;
      mac_index_q <= '0;
      mac_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      insn_q      <= insn_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mac_run_q   <= mac_run_d;
      mac_load_q  <= mac_load_d;
      mac_insn_q  <= mac_insn_d;
      mac_index_q <= mac_index_d;
      mac_data_q  <= mac_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mac_run   = mac_run_q;
  assign mac_load  = mac_load_q;
  assign mac_insn  = mac_insn_q;
  assign mac_index = mac_index_q;
  assign mac_data  = mac_data_q;

endmodule

// File: tb/tb_dmadd_host_loader.sv
// Directed bench for dmadd_host_loader: default build plus a 4-nibble RUN_LAT=0 instance.
module tb_dmadd_host_loader;

  localparam logic [63:0] A  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] A5 = 64'h0123_4567_890B_CDEF;
  localparam logic [63:0] B  = 64'h1234_5678_9ABC_DEF0;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy, mac_run, mac_load;
  logic [1:0]  cmd_insn, mac_insn;
  logic [63:0] cmd_data;
  logic [15:0] rsp_data, mac_out;
  logic [3:0]  mac_index, mac_data;

  logic        cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, busy2, mac_run2, mac_load2;
  logic [1:0]  cmd_insn2, mac_insn2;
  logic [15:0] cmd_data2, rsp_data2, mac_out2;
  logic [3:0]  mac_index2, mac_data2;

  int cyc;
  int n_chk, n_pass, n_fail;
  int acc_cnt, acc_cyc, rsp_cnt, run_cnt, run_cyc, rise_cyc, idle_bad;
  int acc2_cyc, ld2_cnt, ld2_bad, run2_cyc, rise2_cyc;
  logic [15:0] last_rsp;
  logic prev_rv, prev_rv2;
  int         ld_cyc[$];
  logic [3:0] ld_idx[$];
  logic [3:0] ld_dat[$];
  logic [1:0] ld_ins[$];

  dmadd_host_loader dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy), .mac_run(mac_run),
    .mac_load(mac_load), .mac_insn(mac_insn), .mac_index(mac_index),
    .mac_data(mac_data), .mac_out(mac_out)
  );

  dmadd_host_loader #(.NIBBLES(4), .RUN_LAT(0)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_insn(cmd_insn2), .cmd_data(cmd_data2), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready2), .rsp_data(rsp_data2), .busy(busy2), .mac_run(mac_run2),
    .mac_load(mac_load2), .mac_insn(mac_insn2), .mac_index(mac_index2),
    .mac_data(mac_data2), .mac_out(mac_out2)
  );

  // Result model for the second instance changes every cycle.
  assign mac_out2 = 16'(cyc * 7 + 3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_cnt  <= rsp_cnt + 1;
      last_rsp <= rsp_data;
    end
    if (!rst && cmd_valid2 && cmd_ready2) acc2_cyc <= cyc;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (mac_load) begin
      ld_cyc.push_back(cyc);
      ld_idx.push_back(mac_index);
      ld_dat.push_back(mac_data);
      ld_ins.push_back(mac_insn);
    end else if (mac_index != '0 || mac_data != '0) begin
      idle_bad++;
    end
    if (mac_run) begin
      run_cnt++;
      run_cyc = cyc;
    end
    if (rsp_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = rsp_valid;
    if (mac_load2) begin
      if (int'(mac_index2) != ld2_cnt || mac_data2 !== cmd_data2[4*ld2_cnt +: 4]) ld2_bad++;
      ld2_cnt++;
    end
    if (mac_run2) run2_cyc = cyc;
    if (rsp_valid2 && !prev_rv2) rise2_cyc = cyc;
    prev_rv2 = rsp_valid2;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid) break;
      step();
    end
    chk(tag, 64'(rsp_valid), 64'd1);
  endtask

  task automatic clear_ld();
    ld_cyc.delete();
    ld_idx.delete();
    ld_dat.delete();
    ld_ins.delete();
  endtask

  int bad, first_acc, run_base, rsp_base, acc_base;
  bit seen;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_insn = 2'b00; cmd_data = '0; rsp_ready = 1'b0;
    mac_out = 16'hBEEF;
    cmd_valid2 = 1'b0; cmd_insn2 = 2'b00; cmd_data2 = '0; rsp_ready2 = 1'b0;
    step(); step();

    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_flags", 64'({busy, rsp_valid, mac_run, mac_load}), 64'd0);
    chk("rst_mac", 64'({mac_insn, mac_index, mac_data}), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_ready2", 64'(cmd_ready2), 64'd1);
    rst = 1'b0;
    step();

    // Single command with full serialisation.
    clear_ld();
    cmd_insn = 2'b01; cmd_data = A; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_rsp("rsp1_valid");
    chk("acc1_cnt", 64'(acc_cnt), 64'd1);
    chk("ld1_cnt", 64'(ld_cyc.size()), 64'd16);
    bad = 0;
    for (int k = 0; k < ld_cyc.size(); k++)
      if (int'(ld_idx[k]) != k || ld_dat[k] !== 4'(15 - k) ||
          ld_cyc[k] != acc_cyc + 1 + k || ld_ins[k] !== 2'b01) bad++;
    chk("ld1_seq", 64'(bad), 64'd0);
    chk("run1_cyc", 64'(run_cyc), 64'(acc_cyc + 17));
    chk("run1_cnt", 64'(run_cnt), 64'd1);
    chk("rsp1_cyc", 64'(rise_cyc), 64'(acc_cyc + 20));
    chk("rsp1_data", 64'(rsp_data), 64'hBEEF);

    // Backpressure: response held, new command refused.
    cmd_valid = 1'b1; cmd_data = B; cmd_insn = 2'b10; mac_out = 16'h1234;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    chk("bp_no_accept", 64'(acc_cnt), 64'd1);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    step();
    chk("bp_release_idle", 64'({cmd_ready, busy, rsp_valid}), 64'b100);
    chk("bp_rsp_cnt", 64'(rsp_cnt), 64'd1);
    chk("bp_rsp_val", 64'(last_rsp), 64'hBEEF);
    rsp_ready = 1'b0;

`ifdef DMADD_SKIP_UNCHANGED_EN
    // Identical word: no loads, run right after accept.
    clear_ld();
    cmd_insn = 2'b01; cmd_data = A; cmd_valid = 1'b1; mac_out = 16'h1111;
    step();
    cmd_valid = 1'b0;
    wait_rsp("skip_same_valid");
    chk("skip_same_ld", 64'(ld_cyc.size()), 64'd0);
    chk("skip_same_run", 64'(run_cyc), 64'(acc_cyc + 1));
    chk("skip_same_rsp", 64'(rise_cyc), 64'(acc_cyc + 4));
    chk("skip_same_data", 64'(rsp_data), 64'h1111);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;

    // Only nibble 5 changes.
    clear_ld();
    cmd_data = A5; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_rsp("skip_one_valid");
    chk("skip_one_ld", 64'(ld_cyc.size()), 64'd1);
    chk("skip_one_slot", (ld_cyc.size() > 0) ? 64'({ld_idx[0], ld_dat[0]}) : 64'hx, 64'h50);
    chk("skip_one_run", 64'(run_cyc), 64'(acc_cyc + 2));
    chk("skip_one_rsp", 64'(rise_cyc), 64'(acc_cyc + 5));
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
`endif

    // Reset in the middle of LOAD.
    clear_ld();
    run_base = run_cnt; rsp_base = rsp_cnt;
    cmd_insn = 2'b11; cmd_data = B; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (mac_load && mac_index == 4'd7) seen = 1'b1;
      else step();
    end
    chk("rstmid_reached7", 64'(seen), 64'd1);
    rst = 1'b1;
    step();
    chk("rstmid_flags", 64'({cmd_ready, busy, rsp_valid, mac_run, mac_load}), 64'b10000);
    chk("rstmid_mac", 64'({mac_insn, mac_index, mac_data, rsp_data}), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step();
    chk("rstmid_no_run", 64'(run_cnt), 64'(run_base));
    chk("rstmid_no_rsp", 64'({rsp_valid, 8'(rsp_cnt - rsp_base)}), 64'd0);

    // Back-to-back commands with rsp_ready tied high.
    clear_ld();
    acc_base = acc_cnt; rsp_base = rsp_cnt;
    rsp_ready = 1'b1; mac_out = 16'hC0DE;
    cmd_insn = 2'b10; cmd_data = A; cmd_valid = 1'b1;
    step();
    first_acc = acc_cyc;
    cmd_insn = 2'b11; cmd_data = B;
    for (int i = 0; i < 60; i++) begin
      if (acc_cnt == acc_base + 2) break;
      step();
    end
    cmd_valid = 1'b0;
    chk("b2b_acc_cnt", 64'(acc_cnt - acc_base), 64'd2);
    chk("b2b_second_acc", 64'(acc_cyc), 64'(first_acc + 21));
    for (int i = 0; i < 60; i++) begin
      if (rsp_cnt == rsp_base + 2) break;
      step();
    end
    for (int i = 0; i < 5; i++) step();
    chk("b2b_rsp_cnt", 64'(rsp_cnt - rsp_base), 64'd2);
    chk("b2b_rsp_val", 64'(last_rsp), 64'hC0DE);
    chk("b2b_ld_cnt", 64'(ld_cyc.size()), 64'd32);
    bad = 0;
    for (int k = 0; k < ld_cyc.size(); k++) begin
      if (k < 16) begin
        if (int'(ld_idx[k]) != k || ld_dat[k] !== 4'(15 - k) || ld_ins[k] !== 2'b10) bad++;
      end else begin
        if (int'(ld_idx[k]) != k - 16 || ld_dat[k] !== 4'(32 - k) || ld_ins[k] !== 2'b11) bad++;
      end
    end
    chk("b2b_ld_seq", 64'(bad), 64'd0);
    rsp_ready = 1'b0;

    // RUN_LAT=0, 4 nibbles: result is mac_out of the run cycle.
    cmd_insn2 = 2'b01; cmd_data2 = 16'hA5C3; cmd_valid2 = 1'b1;
    step();
    cmd_valid2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid2) break;
      step();
    end
    chk("rl0_valid", 64'(rsp_valid2), 64'd1);
    chk("rl0_loads", 64'({8'(ld2_cnt), 8'(ld2_bad)}), 64'h0400);
    chk("rl0_run_cyc", 64'(run2_cyc), 64'(acc2_cyc + 5));
    chk("rl0_rsp_cyc", 64'(rise2_cyc), 64'(acc2_cyc + 6));
    chk("rl0_data", 64'(rsp_data2), 64'(16'((acc2_cyc + 5) * 7 + 3)));
    rsp_ready2 = 1'b1;
    step();
    chk("rl0_idle", 64'({cmd_ready2, rsp_valid2, busy2}), 64'b100);

    chk("idle_index_data_zero", 64'(idle_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
